// File: rtl/timer_prog.sv
// Programmable timer: run-time period, prescale and periodic/one-shot mode with start/stop control.
// Optional prescaler is built only when TIMER_PRESCALER_EN is defined; otherwise R is effectively 0.
module timer_prog #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [WIDTH-1:0]       period,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic [WIDTH-1:0]       y,
  output logic                   tick,
  output logic                   busy,
  output logic                   done,
  output logic                   o_dbg_state
);

  // start/stop are single-cycle pulses, not a handshake; stop has priority over start.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] Y_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_tick;
  logic             r_done;
  logic             w_run;
  logic             w_strobe;
  logic             w_wrap;

  assign w_run = (r_state == S_RUN);

`ifdef TIMER_PRESCALER_EN
  localparam logic [PRESC_WIDTH-1:0] PC_ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_pc;
  logic                   w_pc_term;

  assign w_pc_term = (r_pc == r_presc);
  assign w_strobe  = w_run && ce && w_pc_term;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pc    <= '0;
    end else if (!stop) begin
      if (start) begin
        r_presc <= presc;
        r_pc    <= '0;
      end else if (w_run && ce) begin
        r_pc <= w_pc_term ? '0 : r_pc + PC_ONE;
      end
    end
  end
`else
  logic w_unused_presc;
  assign w_unused_presc = ^presc;
  assign w_strobe       = w_run && ce;
`endif

  assign w_wrap = w_strobe && (r_y == r_period);

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else if (start) begin
      w_state_nxt = S_RUN;
    end else if (w_wrap && r_mode) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y      <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (!stop) begin
        if (start) begin
          r_period <= period;
          r_mode   <= mode;
          r_y      <= '0;
          r_done   <= 1'b0;
        end else if (w_strobe) begin
          // Compare-before-increment keeps y within 0..P with no wrap through 2^WIDTH.
          if (w_wrap) begin
            r_y    <= '0;
            r_tick <= 1'b1;
            if (r_mode) begin
              r_done <= 1'b1;
            end
          end else begin
            r_y <= r_y + Y_ONE;
          end
        end
      end
    end
  end

  assign y           = r_y;
  assign tick        = r_tick;
  assign busy        = w_run;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_prog.sv
// Self-checking bench for timer_prog: arithmetic reference model plus directed and random scenarios.
// Works with or without TIMER_PRESCALER_EN (model uses R=0 when the prescaler is not built).
module tb_timer_prog;

`ifdef TIMER_PRESCALER_EN
  localparam bit PRESC_ON = 1'b1;
`else
  localparam bit PRESC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  presc = '0;
  logic [15:0] y;
  logic        tick;
  logic        busy;
  logic        done;
  logic        dbg_state;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model state: enabled-cycle count since start drives everything
  bit          m_run, m_mode, m_tick, m_done;
  longint      m_P, m_R, m_n;
  logic [15:0] m_y;

  timer_prog #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .stop(stop), .mode(mode),
    .period(period), .presc(presc), .y(y), .tick(tick), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    m_tick = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_y = '0; m_done = 0; m_P = 0; m_R = 0; m_mode = 0; m_n = 0;
    end else if (stop) begin
      m_run = 0;
    end else if (start) begin
      m_P = period; m_R = PRESC_ON ? longint'(presc) : 0; m_mode = mode;
      m_n = 0; m_y = '0; m_done = 0; m_run = 1;
    end else if (m_run && ce) begin
      m_n++;
      m_y = 16'((m_n / (m_R + 1)) % (m_P + 1));
      if (m_n % ((m_P + 1) * (m_R + 1)) == 0) begin
        m_tick = 1'b1;
        if (m_mode) begin
          m_done = 1; m_run = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    step(); step();
    rst_n = 1'b1;
    n_chk++;
    if ({y, tick, busy, done, dbg_state} !== 20'h0) begin
      $display("FAIL reset: y=%0d tick=%b busy=%b done=%b st=%b required all 0", y, tick, busy, done, dbg_state);
    end else n_pass++;
  endtask

  task automatic test_periodic();
    int k, last, nt;
    ce = 1; period = 4; presc = 0; mode = 0; start = 1;
    step(); k = cyc; last = -1; nt = 0;
    for (int i = 0; i < 31; i++) begin
      if (i > 0) step();
      n_chk++;
      if ({y, tick, busy, done, dbg_state} !== {m_y, m_tick, m_run, m_done, m_run}) begin
        $display("FAIL periodic c%0d: y=%0d t=%b b=%b d=%b required y=%0d t=%b b=%b d=%b", cyc, y, tick, busy, done, m_y, m_tick, m_run, m_done);
      end else n_pass++;
      if (tick) begin
        n_chk++;
        if ((last < 0 ? cyc - k : cyc - last) !== 5) begin
          $display("FAIL periodic_spacing: got %0d required 5", last < 0 ? cyc - k : cyc - last);
        end else n_pass++;
        last = cyc; nt++;
      end
    end
    n_chk++;
    if (nt !== 6) $display("FAIL periodic_count: got %0d ticks required 6", nt);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int k, nt, exp_lat;
    exp_lat = 3 * (PRESC_ON ? 4 : 1);
    period = 2; presc = 3; mode = 1; start = 1;
    step(); k = cyc; nt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++;
      if ({y, tick, busy, done, dbg_state} !== {m_y, m_tick, m_run, m_done, m_run}) begin
        $display("FAIL oneshot c%0d: y=%0d t=%b b=%b d=%b required y=%0d t=%b b=%b d=%b", cyc, y, tick, busy, done, m_y, m_tick, m_run, m_done);
      end else n_pass++;
      if (tick) begin
        nt++;
        n_chk++;
        if ({cyc - k, done, busy} !== {exp_lat, 1'b1, 1'b0}) begin
          $display("FAIL oneshot_expiry: lat=%0d done=%b busy=%b required lat=%0d done=1 busy=0", cyc - k, done, busy, exp_lat);
        end else n_pass++;
      end
    end
    n_chk++;
    if ({nt, y, done} !== {32'd1, 16'd0, 1'b1}) begin
      $display("FAIL oneshot_final: ticks=%0d y=%0d done=%b required 1 0 1", nt, y, done);
    end else n_pass++;
  endtask

  task automatic test_ce_toggle();
    int last;
    bit ce_s;
    period = 9; presc = 0; mode = 0; ce = 1; start = 1;
    step(); last = -1;
    for (int i = 0; i < 90; i++) begin
      ce = ~ce; ce_s = ce;
      step();
      n_chk++;
      if ({y, tick, busy, done} !== {m_y, m_tick, m_run, m_done}) begin
        $display("FAIL ce_toggle c%0d: y=%0d t=%b required y=%0d t=%b", cyc, y, tick, m_y, m_tick);
      end else n_pass++;
      if (tick) begin
        n_chk++;
        if (!ce_s || (last >= 0 && cyc - last != 20)) begin
          $display("FAIL ce_spacing: ce=%b spacing=%0d required ce=1 spacing 20", ce_s, cyc - last);
        end else n_pass++;
        last = cyc;
      end
    end
    ce = 1;
  endtask

  task automatic test_stop_start();
    int budget;
    period = 7; presc = 0; mode = 0; ce = 1; start = 1;
    step();
    budget = 50;
    while (y !== 16'd5 && budget > 0) begin
      step(); budget--;
    end
    n_chk++;
    if (budget == 0) $display("FAIL stop_wait: y=%0d never reached required 5", y);
    else n_pass++;
    stop = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin start = 1; stop = 1; end
      step();
      n_chk++;
      if ({y, tick, busy, done, dbg_state} !== {m_y, m_tick, m_run, m_done, m_run} || y !== 16'd5) begin
        $display("FAIL stop_hold i%0d: y=%0d t=%b b=%b required y=%0d t=%b b=%b", i, y, tick, busy, m_y, m_tick, m_run);
      end else n_pass++;
    end
    start = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if ({y, tick, busy, done, dbg_state} !== {m_y, m_tick, m_run, m_done, m_run}) begin
        $display("FAIL resume i%0d: y=%0d t=%b b=%b required y=%0d t=%b b=%b", i, y, tick, busy, m_y, m_tick, m_run);
      end else n_pass++;
    end
  endtask

  task automatic test_p_zero();
    period = 0; presc = 0; mode = 0; ce = 1; start = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if ({y, tick, busy} !== {m_y, m_tick, m_run} || tick !== 1'b1) begin
        $display("FAIL p_zero i%0d: y=%0d t=%b required y=0 t=1", i, y, tick);
      end else n_pass++;
    end
  endtask

  task automatic test_restart();
    int k, budget;
    period = 9; presc = 0; mode = 0; ce = 1; start = 1;
    step();
    repeat (6) step();
    period = 3; start = 1;
    step(); k = cyc; budget = 20;
    do begin
      step(); budget--;
    end while (!tick && budget > 0);
    n_chk++;
    if (budget == 0 || cyc - k != 4 || y !== 16'd0) begin
      $display("FAIL restart: tick after %0d cycles y=%0d required 4 and 0", cyc - k, y);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      ce     = ($urandom_range(0, 3) != 0);
      start  = ($urandom_range(0, 39) == 0);
      stop   = ($urandom_range(0, 59) == 0);
      mode   = $urandom_range(0, 1);
      period = 16'($urandom_range(0, 12));
      presc  = 8'($urandom_range(0, 3));
      step();
      n_chk++;
      if ({y, tick, busy, done, dbg_state} !== {m_y, m_tick, m_run, m_done, m_run}) begin
        $display("FAIL random c%0d: y=%0d t=%b b=%b d=%b required y=%0d t=%b b=%b d=%b", cyc, y, tick, busy, done, m_y, m_tick, m_run, m_done);
      end else n_pass++;
    end
    rst_n = 1; ce = 1;
  endtask

  task automatic test_reset_mid();
    period = 20; presc = 0; mode = 0; ce = 1; start = 1;
    step();
    repeat (7) step();
    rst_n = 0; start = 1;
    step();
    rst_n = 1;
    n_chk++;
    if ({y, tick, busy, done, dbg_state} !== 20'h0) begin
      $display("FAIL reset_mid: y=%0d tick=%b busy=%b done=%b required all 0", y, tick, busy, done);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_ce_toggle();
    test_stop_start();
    test_p_zero();
    test_restart();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_prog.md
# timer_prog

Programmable timer: next generation of the fixed-modulo counter. The period, prescale ratio and periodic/one-shot mode are set at run time, with start/stop control and busy/done status. It sits alongside the interval counters in the INTRO timing subsystem and drives periodic event strobes (sampling, LED blink, timeouts) from a single system clock.

## Interface
Parameters:
- `WIDTH`, 16: counter width; maximum period is 2^WIDTH cycles of the prescaled strobe.
- `PRESC_WIDTH`, 8: prescaler divisor width.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ce`  in  1  global count enable; when 0, the prescaler and counter freeze.
- `start`  in  1  single-cycle pulse; latches configuration and (re)starts counting.
- `stop`  in  1  single-cycle pulse; aborts counting.
- `mode`  in  1  0 = periodic, 1 = one-shot; latched on `start`.
- `period`  in  WIDTH  terminal count P; counter runs 0..P; latched on `start`.
- `presc`  in  PRESC_WIDTH  prescale R; one strobe per R+1 enabled cycles; latched on `start`.
- `y`  out  WIDTH  current count.
- `tick`  out  1  one-cycle pulse on each wrap or expiry.
- `busy`  out  1  high while in RUN.
- `done`  out  1  sticky one-shot expiry flag; cleared by `start`.

## Operation
- Reset (`rst_n`=0 at an edge) forces these values:
  - state IDLE; `y`=0, `tick`=0, `busy`=0, `done`=0.
  - internal period, prescale and mode registers = 0.
  - prescaler counter `pc`=0.
- States:
  - IDLE: `y` holds its value, no strobes.
  - RUN: counting.
- `start` (from any state):
  - latches `period`, `presc` and `mode`.
  - sets `y`=0, `pc`=0, `done`=0, `busy`=1; goes to RUN.
  - `start` in RUN therefore restarts cleanly.
- `stop`: goes to IDLE, `busy`=0. `y` holds its value; no `tick`; `done` is unchanged.
- `start` and `stop` in the same cycle: `stop` wins.
- Prescaler, in RUN with `ce`=1:
  - if `pc`==R: strobe, and `pc`<=0.
  - otherwise `pc`<=`pc`+1.
- On a strobe:
  - `y`<P: `y`<=`y`+1.
  - `y`==P, periodic: `y`<=0, `tick`<=1.
  - `y`==P, one-shot: `y`<=0, `tick`<=1, `done`<=1, `busy`<=0, goes to IDLE.
- `tick` is 0 in every cycle not listed above, including every cycle with `ce`=0.
- P=0: every strobe produces `tick`, and `y` stays at 0.
- Arithmetic is unsigned; `y` never exceeds P and never wraps through 2^WIDTH.
- `ce` is ignored in IDLE, and `start`/`stop` act regardless of `ce`.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge k gives `busy`=1 and `y`=0 after edge k.
- With R=0, `y`=n after edge k+n.
- First increment occurs at edge k+R+1.
- With `ce` held at 1:
  - periodic `tick` spacing is exactly (P+1)(R+1) cycles.
  - the first `tick` is asserted after edge k+(P+1)(R+1).
- `tick` and `y`=0 become visible on the same edge.
- One-shot: `tick`, `done`=1 and `busy`=0 all appear on the same edge.
- `ce` low for m cycles delays every later event by exactly m cycles.
- Reset mid-run takes effect at the next edge and overrides `start`/`stop`.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - prescaler is built as described above.
  - the `presc` port is functional.
- Not defined:
  - no prescaler logic is instantiated; the strobe equals `ce` in RUN (R is effectively 0).
  - the `presc` port remains for interface compatibility but is ignored.
  - all timing formulas apply with R=0.

## Test plan
- Reset, then `start` with P=4, R=0, mode=0, `ce`=1:
  - `y` runs 0,1,2,3,4,0,...
  - `tick` every 5 cycles.
  - `busy`=1, `done`=0.
- P=2, R=3, mode=1:
  - `tick` once, 12 cycles after `start`.
  - `done`=1 and `busy`=0 on the same edge.
  - `y`=0 thereafter, with no further ticks.
- P=9, R=0, `ce` toggling 1,0 every cycle:
  - `tick` spacing is 20 cycles.
  - `tick` is never high while `ce`=0.
- Periodic P=7; `stop` when `y`=5:
  - `y` holds at 5, `busy`=0, no tick.
- Then `start` and `stop` in the same cycle:
  - remains IDLE.
- Then `start` alone:
  - `y`=0, counting resumes.
- P=0, R=0 periodic:
  - `tick` high every cycle.
- Restart mid-run with P=3:
  - next tick 4 cycles after the restart.
- `rst_n`=0 mid-count:
  - all outputs are 0 at the next edge.
